// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the instruction memory port and decode.
// The master side is the fetch controller; the slave side is its environment.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              halted;
  logic              fault;

  modport master (
    output imem_addr, imem_en, instr_valid, instr_out, instr_pc, halted, fault,
    input  imem_data, redirect_valid, redirect_pc, halt, instr_ready
  );

  modport slave (
    input  imem_addr, imem_en, instr_valid, instr_out, instr_pc, halted, fault,
    output imem_data, redirect_valid, redirect_pc, halt, instr_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues reads to a 1-cycle-latency instruction memory and
// queues returned words in a 2-entry buffer for decode, with redirect, halt and range fault.
module imem_fetch_ctrl #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rsta,
  imem_fetch_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {ST_FETCH, ST_HALTED, ST_FAULT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              inflight_reg;
  logic [1:0]        count_reg;
  logic              rd_ptr_reg, wr_ptr_reg;

  logic              pc_in_range;
  logic              pop, push, issue;
  logic [1:0]        occ_after_pop;
  logic [2:0]        credit_used;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;

  assign pc_in_range   = (pc_reg < PC_LIMIT);
  assign pop           = (count_reg != 2'd0) && bus.instr_ready;
  // A redirect squashes the word returning this cycle.
  assign push          = inflight_reg && !bus.redirect_valid;
  assign occ_after_pop = count_reg - {1'b0, pop};
  assign credit_used   = {1'b0, occ_after_pop} + {2'b00, inflight_reg};

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (!pc_in_range) begin
          state_next = ST_FAULT;
        end else if (bus.halt && !inflight_reg) begin
          state_next = ST_HALTED;
        end
        issue = rsta && !bus.halt && !bus.redirect_valid && pc_in_range &&
                (credit_used < 3'd2);
      end
      ST_HALTED: begin
        if (!bus.halt) begin
          state_next = ST_FETCH;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
    // Redirect overrides everything; nothing is in flight afterwards.
    if (bus.redirect_valid) begin
      if (bus.redirect_pc >= PC_LIMIT) begin
        state_next = ST_FAULT;
      end else if (bus.halt) begin
        state_next = ST_HALTED;
      end else begin
        state_next = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rsta) begin
      state_reg       <= ST_FETCH;
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      count_reg       <= 2'd0;
      rd_ptr_reg      <= 1'b0;
      wr_ptr_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (bus.redirect_valid) begin
        pc_reg       <= bus.redirect_pc;
        inflight_reg <= 1'b0;
        count_reg    <= 2'd0;
        rd_ptr_reg   <= 1'b0;
        wr_ptr_reg   <= 1'b0;
      end else begin
        inflight_reg <= issue;
        if (issue) begin
          pc_reg          <= pc_reg + ADDR_W'(1);
          inflight_pc_reg <= pc_reg;
        end
        count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        if (push) begin
          wr_ptr_reg <= ~wr_ptr_reg;
        end
        if (pop) begin
          rd_ptr_reg <= ~rd_ptr_reg;
        end
      end
    end
  end

  // Entry storage needs no reset: outputs are masked while the buffer is empty.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk) begin
      if (rsta && push && (wr_ptr_reg == 1'(gi))) begin
        data_reg <= bus.imem_data;
        pc_reg   <= inflight_pc_reg;
      end
    end
  end

  assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
  assign head_pc   = rd_ptr_reg ? g_entry[1].pc_reg   : g_entry[0].pc_reg;

  assign bus.imem_addr   = pc_reg;
  assign bus.imem_en     = issue;
  assign bus.instr_valid = (count_reg != 2'd0);
  assign bus.instr_out   = (count_reg != 2'd0) ? head_data : '0;
  assign bus.instr_pc    = (count_reg != 2'd0) ? head_pc : '0;
  assign bus.halted      = rsta && bus.halt && !inflight_reg;
  assign bus.fault       = (state_reg == ST_FAULT);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized run, each delivered
// instruction checked against an in-order PC scoreboard over a preloaded memory image.
module tb_imem_fetch_ctrl;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic clk;
  logic rsta;
  int   tests;
  int   fails;
  int   delivered;

  logic [DW-1:0] mem [0:DEPTH-1];

  // Scoreboard: PC expected at the next handshake, plus hold-stability tracking.
  logic [AW-1:0] exp_pc;
  logic          hold_v;
  logic [AW-1:0] hold_pc;
  logic [DW-1:0] hold_out;

  imem_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  imem_fetch_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk (clk),
    .rsta(rsta),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one cycle latency.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr[6:0]];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe the current cycle (inputs already applied), update the model, advance one cycle.
  task automatic step();
    #1;
    if (hold_v) begin
      check("hold_valid", 64'(bus.instr_valid), 64'd1);
      check("hold_pc", 64'(bus.instr_pc), 64'(hold_pc));
      check("hold_out", 64'(bus.instr_out), 64'(hold_out));
    end
    if (bus.imem_en === 1'b1) begin
      check("issue_legal",
            64'((bus.imem_addr < DEPTH) && !bus.halt && !bus.redirect_valid && rsta), 64'd1);
    end
    hold_v   = rsta && !bus.redirect_valid && bus.instr_valid && !bus.instr_ready;
    hold_pc  = bus.instr_pc;
    hold_out = bus.instr_out;
    if (!rsta) begin
      exp_pc = '0;
    end else begin
      if (bus.instr_valid && bus.instr_ready) begin
        $display("[TB] t=%0t deliver pc=%0d instr=%08h", $time, bus.instr_pc, bus.instr_out);
        check("deliver_pc", 64'(bus.instr_pc), 64'(exp_pc));
        check("deliver_data", 64'(bus.instr_out), 64'(mem[exp_pc[6:0]]));
        exp_pc = exp_pc + 1;
        delivered++;
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rsta = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    rsta = 1'b1;
    delivered = 0;
  endtask

  initial begin
    tests = 0; fails = 0; delivered = 0;
    exp_pc = '0; hold_v = 1'b0; hold_pc = '0; hold_out = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rsta = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    bus.instr_ready = 1'b0;

    // Reset state
    do_reset(3);
    rsta = 1'b0;
    #1;
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_out", 64'(bus.instr_out), 64'd0);
    check("rst_pc", 64'(bus.instr_pc), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_en", 64'(bus.imem_en), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    step();

    // Streaming from reset: latency, full memory sweep, fault at end, redirect recovery
    rsta = 1'b1; delivered = 0;
    bus.instr_ready = 1'b1;
    #1;
    check("c0_en", 64'(bus.imem_en), 64'd1);
    check("c0_addr", 64'(bus.imem_addr), 64'd0);
    check("c0_valid", 64'(bus.instr_valid), 64'd0);
    step();
    check("c1_en", 64'(bus.imem_en), 64'd1);
    check("c1_addr", 64'(bus.imem_addr), 64'd1);
    check("c1_valid", 64'(bus.instr_valid), 64'd0);
    step();
    check("c2_valid", 64'(bus.instr_valid), 64'd1);
    check("c2_pc", 64'(bus.instr_pc), 64'd0);
    for (int i = 0; i < 300 && !bus.fault; i++) step();
    check("sweep_fault", 64'(bus.fault), 64'd1);
    for (int i = 0; i < 4; i++) step();
    check("sweep_count", 64'(delivered), 64'd128);
    check("fault_en", 64'(bus.imem_en), 64'd0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 5;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("redir_fault_clr", 64'(bus.fault), 64'd0);
    delivered = 0;
    for (int i = 0; i < 10; i++) step();
    check("redir5_progress", 64'(delivered > 0), 64'd1);

    // Backpressure: two entries held, no issue, no gap on release
    do_reset(2);
    bus.instr_ready = 1'b0;
    step();
    step();
    for (int c = 2; c <= 6; c++) begin
      #1;
      check("stall_valid", 64'(bus.instr_valid), 64'd1);
      check("stall_pc", 64'(bus.instr_pc), 64'd0);
      check("stall_en", 64'(bus.imem_en), 64'd0);
      step();
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("release_valid", 64'(bus.instr_valid), 64'd1);
      step();
    end

    // Redirect with a full buffer, then redirect while streaming
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 40;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("flush_valid", 64'(bus.instr_valid), 64'd0);
    for (int i = 0; i < 10; i++) step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 90;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Halt mid-stream
    bus.halt = 1'b1;
    #1;
    check("halt_en", 64'(bus.imem_en), 64'd0);
    step();
    check("halt_inflight_valid", 64'(bus.instr_valid), 64'd1);
    check("halt_halted", 64'(bus.halted), 64'd1);
    step();
    check("halt_drained", 64'(bus.instr_valid), 64'd0);
    for (int i = 0; i < 3; i++) step();
    bus.halt = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("resume_valid", 64'(bus.instr_valid), 64'd1);

    // One-cycle reset mid-stream
    rsta = 1'b0;
    step();
    rsta = 1'b1;
    #1;
    check("rerst_valid", 64'(bus.instr_valid), 64'd0);
    check("rerst_fault", 64'(bus.fault), 64'd0);
    check("rerst_addr", 64'(bus.imem_addr), 64'd0);
    check("rerst_en", 64'(bus.imem_en), 64'd1);
    for (int i = 0; i < 10; i++) step();

    // Redirect to an out-of-range PC faults on the next cycle
    bus.redirect_valid = 1'b1; bus.redirect_pc = 200;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("oor_fault", 64'(bus.fault), 64'd1);
    check("oor_en", 64'(bus.imem_en), 64'd0);
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 0;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("oor_clear", 64'(bus.fault), 64'd0);

    // Randomized traffic against the scoreboard
    delivered = 0;
    for (int n = 0; n < 1500; n++) begin
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 99) < 3);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(120, 127))
                                                     : AW'($urandom_range(0, 127));
      if ($urandom_range(0, 99) < 4) bus.halt = !bus.halt;
      step();
    end
    check("random_progress", 64'(delivered > 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
